// File: rtl/sad_search_controller_pkg.sv
// Shared definitions for the full-search block-match controller and the SAD adder:
// FSM state encoding, default SAD width and a width helper for the candidate counters.
package sad_search_controller_pkg;

    localparam int SAD_W_DEFAULT = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WAIT   = 3'd2,
        UPDATE = 3'd3,
        DONE   = 3'd4
    } state_e;

    // Counter width for n distinct positions, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sad_search_controller_comparitor.sv
// Unsigned min comparator: the new value wins when it is less than or equal to the
// current one, so ties resolve in favour of the newer candidate.
module Comparitor
    import sad_search_controller_pkg::*;
#(
    parameter int W = SAD_W_DEFAULT
) (
    input  logic [W-1:0] new_i,
    input  logic [W-1:0] cur_i,
    output logic [W-1:0] min_o,
    output logic         take_new_o
);

    assign take_new_o = (new_i <= cur_i);
    assign min_o      = take_new_o ? new_i : cur_i;

endmodule

// File: rtl/sad_search_controller.sv
// Full-search block-match sequencer: walks every candidate position in raster order,
// requests one SAD per candidate and tracks the minimum together with its position.
module sad_search_controller
    import sad_search_controller_pkg::*;
#(
    parameter  int FRAME_W = 64,
    parameter  int FRAME_H = 64,
    parameter  int WIN_W   = 4,
    parameter  int WIN_H   = 4,
    parameter  int SAD_W   = SAD_W_DEFAULT,
    localparam int X_W     = clog2_min1(FRAME_W - WIN_W + 1),
    localparam int Y_W     = clog2_min1(FRAME_H - WIN_H + 1)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             start,
    output logic             sad_req,
    output logic [X_W-1:0]   cand_x,
    output logic [Y_W-1:0]   cand_y,
    input  logic             sad_valid,
    input  logic [SAD_W-1:0] sad_value,
    output logic             busy,
    output logic             done,
    output logic [SAD_W-1:0] best_sad,
    output logic [X_W-1:0]   best_x,
    output logic [Y_W-1:0]   best_y
);

    localparam logic [X_W-1:0] XMAX = X_W'(FRAME_W - WIN_W);
    localparam logic [Y_W-1:0] YMAX = Y_W'(FRAME_H - WIN_H);

    state_e             state_q, state_d;
    logic [X_W-1:0]     cand_x_q, cand_x_d;
    logic [Y_W-1:0]     cand_y_q, cand_y_d;
    logic [SAD_W-1:0]   sad_cap_q, sad_cap_d;
    logic [SAD_W-1:0]   best_sad_q, best_sad_d;
    logic [X_W-1:0]     best_x_q, best_x_d;
    logic [Y_W-1:0]     best_y_q, best_y_d;
    logic [SAD_W-1:0]   cmp_min;
    logic               cmp_take;
    logic               last_cand;

    Comparitor #(.W(SAD_W)) u_cmp (
        .new_i      (sad_cap_q),
        .cur_i      (best_sad_q),
        .min_o      (cmp_min),
        .take_new_o (cmp_take)
    );

    assign last_cand = (cand_x_q == XMAX) && (cand_y_q == YMAX);

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d    = state_q;
        cand_x_d   = cand_x_q;
        cand_y_d   = cand_y_q;
        sad_cap_d  = sad_cap_q;
        best_sad_d = best_sad_q;
        best_x_d   = best_x_q;
        best_y_d   = best_y_q;
        sad_req    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cand_x_d   = '0;
                    cand_y_d   = '0;
                    best_sad_d = '1;
                    best_x_d   = '0;
                    best_y_d   = '0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                sad_req = 1'b1;
                busy    = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (sad_valid) begin
                    sad_cap_d = sad_value;
                    state_d   = UPDATE;
                end
            end
            UPDATE: begin
                busy = 1'b1;
                if (cmp_take) begin
                    best_sad_d = cmp_min;
                    best_x_d   = cand_x_q;
                    best_y_d   = cand_y_q;
                end
                // The last candidate stays on the outputs after the search ends.
                if (last_cand) begin
                    state_d = DONE;
                end else begin
                    state_d = ISSUE;
                    if (cand_x_q == XMAX) begin
                        cand_x_d = '0;
                        cand_y_d = cand_y_q + Y_W'(1);
                    end else begin
                        cand_x_d = cand_x_q + X_W'(1);
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        // NOTE: non-blocking so every register updates from its pre-edge value.
        if (Rst) begin
            state_q    <= IDLE;
            cand_x_q   <= '0;
            cand_y_q   <= '0;
            sad_cap_q  <= '0;
            best_sad_q <= '0;
            best_x_q   <= '0;
            best_y_q   <= '0;
        end else begin
            state_q    <= state_d;
            cand_x_q   <= cand_x_d;
            cand_y_q   <= cand_y_d;
            sad_cap_q  <= sad_cap_d;
            best_sad_q <= best_sad_d;
            best_x_q   <= best_x_d;
            best_y_q   <= best_y_d;
        end
    end

    assign cand_x   = cand_x_q;
    assign cand_y   = cand_y_q;
    assign best_sad = best_sad_q;
    assign best_x   = best_x_q;
    assign best_y   = best_y_q;

endmodule

// File: tb/tb_sad_search_controller.sv
// Directed bench: a 4x4 frame / 2x2 window controller driven by a latency-L datapath
// model, plus a window-equals-frame instance for the single-candidate case.
module tb_sad_search_controller;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;

    logic        start = 1'b0;
    logic        sad_valid = 1'b0;
    logic [31:0] sad_value = '0;
    logic        sad_req, busy, done;
    logic [1:0]  cand_x, cand_y, best_x, best_y;
    logic [31:0] best_sad;

    logic        start_f = 1'b0;
    logic        valid_f = 1'b0;
    logic [31:0] value_f = '0;
    logic        req_f, busy_f, done_f;
    logic [0:0]  cx_f, cy_f, bx_f, by_f;
    logic [31:0] best_f;

    int checks = 0;
    int errors = 0;

    logic [31:0] sad_tab [9];
    int n_req, done_cyc, stable_err, order_err;
    bit aborted;

    always #5 Clk = ~Clk;

    sad_search_controller #(
        .FRAME_W(4), .FRAME_H(4), .WIN_W(2), .WIN_H(2), .SAD_W(32)
    ) dut (
        .Clk(Clk), .Rst(Rst), .start(start), .sad_req(sad_req),
        .cand_x(cand_x), .cand_y(cand_y), .sad_valid(sad_valid),
        .sad_value(sad_value), .busy(busy), .done(done),
        .best_sad(best_sad), .best_x(best_x), .best_y(best_y)
    );

    sad_search_controller #(
        .FRAME_W(4), .FRAME_H(4), .WIN_W(4), .WIN_H(4), .SAD_W(32)
    ) dut_full (
        .Clk(Clk), .Rst(Rst), .start(start_f), .sad_req(req_f),
        .cand_x(cx_f), .cand_y(cy_f), .sad_valid(valid_f),
        .sad_value(value_f), .busy(busy_f), .done(done_f),
        .best_sad(best_f), .best_x(bx_f), .best_y(by_f)
    );

    // Drives one search on the 2x2-window instance with a latency-lat datapath model.
    task automatic run_search(input int lat, input bit spur, input int abort_idx);
        int  cyc, req_cyc, idx;
        bit  pending, fin;
        logic [1:0] hx, hy;
        cyc = 0; req_cyc = 0; idx = 0; pending = 0; fin = 0; hx = '0; hy = '0;
        n_req = 0; done_cyc = -1; stable_err = 0; order_err = 0; aborted = 0;
        @(negedge Clk); start = 1'b1;
        @(negedge Clk); start = 1'b0;
        cyc = 1;
        while (!fin && cyc < 2000) begin
            sad_valid = 1'b0;
            start     = 1'b0;
            if (pending) begin
                if (cand_x !== hx || cand_y !== hy || busy !== 1'b1) stable_err++;
                if (abort_idx == n_req - 1 && cyc == req_cyc + 1) begin
                    Rst = 1'b1;
                    aborted = 1;
                    fin = 1;
                end else if (cyc == req_cyc + lat) begin
                    sad_valid = 1'b1;
                    sad_value = sad_tab[idx];
                    pending = 0;
                    idx++;
                end
            end
            if (!fin && sad_req) begin
                if (pending || n_req > 8 || cand_x !== 2'(n_req % 3) ||
                    cand_y !== 2'(n_req / 3) || busy !== 1'b1) order_err++;
                hx = cand_x; hy = cand_y; req_cyc = cyc; pending = 1;
                n_req++;
                if (spur) begin
                    sad_valid = 1'b1;
                    sad_value = 32'd0;
                    if (n_req == 3) start = 1'b1;
                end
            end
            if (!fin && done) begin
                done_cyc = cyc;
                fin = 1;
            end
            if (!fin) begin
                @(negedge Clk);
                cyc++;
            end
        end
        sad_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        repeat (2) @(negedge Clk);
        checks++;
        if ({sad_req, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: got req/busy/done=%b, want 000", {sad_req, busy, done});
        end
        checks++;
        if (best_sad !== 32'd0 || best_x !== 2'd0 || best_y !== 2'd0) begin
            errors++;
            $display("FAIL reset_best: got %0d@(%0d,%0d), want 0@(0,0)", best_sad, best_x, best_y);
        end
        checks++;
        if (cand_x !== 2'd0 || cand_y !== 2'd0) begin
            errors++;
            $display("FAIL reset_cand: got (%0d,%0d), want (0,0)", cand_x, cand_y);
        end
        checks++;
        if (best_f !== 32'd0 || {req_f, busy_f, done_f} !== 3'b000) begin
            errors++;
            $display("FAIL reset_full: got best=%h ctrl=%b, want 0 and 000", best_f, {req_f, busy_f, done_f});
        end
        Rst = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_descending();
        for (int i = 0; i < 9; i++) sad_tab[i] = 32'(9 - i);
        run_search(1, 0, -1);
        checks++;
        if (n_req !== 9 || order_err !== 0 || stable_err !== 0) begin
            errors++;
            $display("FAIL t1_sequence: got reqs=%0d order_err=%0d stable_err=%0d, want 9/0/0", n_req, order_err, stable_err);
        end
        checks++;
        if (done_cyc !== 28) begin
            errors++;
            $display("FAIL t1_done_cycle: got %0d, want 28", done_cyc);
        end
        checks++;
        if (best_sad !== 32'd1 || best_x !== 2'd2 || best_y !== 2'd2) begin
            errors++;
            $display("FAIL t1_best: got %0d@(%0d,%0d), want 1@(2,2)", best_sad, best_x, best_y);
        end
        repeat (3) @(negedge Clk);
        checks++;
        if (best_sad !== 32'd1 || best_x !== 2'd2 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL t1_hold: got %0d@x%0d busy=%b done=%b, want 1@x2 busy=0 done=0", best_sad, best_x, busy, done);
        end
    endtask

    task automatic test_ties();
        for (int i = 0; i < 9; i++) sad_tab[i] = 32'd5;
        run_search(1, 0, -1);
        checks++;
        if (n_req !== 9 || done_cyc !== 28) begin
            errors++;
            $display("FAIL t2_run: got reqs=%0d done=%0d, want 9/28", n_req, done_cyc);
        end
        checks++;
        if (best_sad !== 32'd5 || best_x !== 2'd2 || best_y !== 2'd2) begin
            errors++;
            $display("FAIL t2_tie_best: got %0d@(%0d,%0d), want 5@(2,2)", best_sad, best_x, best_y);
        end
    endtask

    task automatic test_min_mid();
        for (int i = 0; i < 9; i++) sad_tab[i] = (i == 3) ? 32'd0 : 32'd7;
        run_search(1, 0, -1);
        checks++;
        if (best_sad !== 32'd0 || best_x !== 2'd0 || best_y !== 2'd1) begin
            errors++;
            $display("FAIL t3_best: got %0d@(%0d,%0d), want 0@(0,1)", best_sad, best_x, best_y);
        end
    endtask

    task automatic test_latency();
        @(negedge Clk); sad_valid = 1'b1; sad_value = 32'd0;
        @(negedge Clk); sad_valid = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL t4_idle_valid: got busy=%b, want 0", busy);
        end
        sad_tab = '{32'd20, 32'd15, 32'd30, 32'd15, 32'd40, 32'd50, 32'd15, 32'd60, 32'd70};
        run_search(4, 1, -1);
        checks++;
        if (n_req !== 9 || order_err !== 0 || stable_err !== 0) begin
            errors++;
            $display("FAIL t4_sequence: got reqs=%0d order_err=%0d stable_err=%0d, want 9/0/0", n_req, order_err, stable_err);
        end
        checks++;
        if (done_cyc !== 55) begin
            errors++;
            $display("FAIL t4_done_cycle: got %0d, want 55", done_cyc);
        end
        checks++;
        if (best_sad !== 32'd15 || best_x !== 2'd0 || best_y !== 2'd2) begin
            errors++;
            $display("FAIL t4_best: got %0d@(%0d,%0d), want 15@(0,2)", best_sad, best_x, best_y);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 9; i++) sad_tab[i] = 32'd3;
        run_search(2, 0, 4);
        checks++;
        if (!aborted || n_req !== 5) begin
            errors++;
            $display("FAIL t5_abort_point: got aborted=%0d reqs=%0d, want 1/5", aborted, n_req);
        end
        @(negedge Clk);
        checks++;
        if (busy !== 1'b0 || sad_req !== 1'b0 || best_sad !== 32'd0 ||
            cand_x !== 2'd0 || cand_y !== 2'd0) begin
            errors++;
            $display("FAIL t5_after_rst: got busy=%b req=%b best=%0d cand=(%0d,%0d), want 0/0/0/(0,0)",
                     busy, sad_req, best_sad, cand_x, cand_y);
        end
        Rst = 1'b0;
        sad_valid = 1'b1;
        sad_value = 32'd0;
        @(negedge Clk);
        sad_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || best_sad !== 32'd0) begin
            errors++;
            $display("FAIL t5_dropped: got busy=%b best=%0d, want 0/0", busy, best_sad);
        end
        sad_tab = '{32'd8, 32'd6, 32'd9, 32'd6, 32'd2, 32'd7, 32'd3, 32'd9, 32'd4};
        run_search(1, 0, -1);
        checks++;
        if (n_req !== 9 || done_cyc !== 28 || order_err !== 0) begin
            errors++;
            $display("FAIL t5_rerun: got reqs=%0d done=%0d order_err=%0d, want 9/28/0", n_req, done_cyc, order_err);
        end
        checks++;
        if (best_sad !== 32'd2 || best_x !== 2'd1 || best_y !== 2'd1) begin
            errors++;
            $display("FAIL t5_best: got %0d@(%0d,%0d), want 2@(1,1)", best_sad, best_x, best_y);
        end
    endtask

    task automatic test_full_window();
        int cyc, req_cyc, nreq, bad, dcyc;
        bit fin;
        cyc = 0; req_cyc = -10; nreq = 0; bad = 0; dcyc = -1; fin = 0;
        @(negedge Clk); start_f = 1'b1;
        @(negedge Clk); start_f = 1'b0;
        cyc = 1;
        while (!fin && cyc < 100) begin
            valid_f = 1'b0;
            if (cyc == req_cyc + 1) begin
                valid_f = 1'b1;
                value_f = 32'hFFFF_FFFF;
            end
            if (req_f) begin
                nreq++;
                req_cyc = cyc;
                if (cx_f !== 1'b0 || cy_f !== 1'b0) bad++;
            end
            if (done_f) begin
                dcyc = cyc;
                fin = 1;
            end
            if (!fin) begin
                @(negedge Clk);
                cyc++;
            end
        end
        valid_f = 1'b0;
        checks++;
        if (nreq !== 1 || bad !== 0 || dcyc !== 4) begin
            errors++;
            $display("FAIL t6_run: got reqs=%0d bad_cand=%0d done=%0d, want 1/0/4", nreq, bad, dcyc);
        end
        checks++;
        if (best_f !== 32'hFFFF_FFFF || bx_f !== 1'b0 || by_f !== 1'b0) begin
            errors++;
            $display("FAIL t6_best: got %h@(%0d,%0d), want ffffffff@(0,0)", best_f, bx_f, by_f);
        end
    endtask

    initial begin
        test_reset();
        test_descending();
        test_ties();
        test_min_mid();
        test_latency();
        test_reset_mid();
        test_full_window();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
